grant_sequencer: RTL and testbench
==================================

# grant_sequencer

Inverse of the 8-input priority encoder: takes the 4-bit winning index from the encoder and turns it into a one-hot grant strobe. The strobe is held under an ack handshake with a timeout. It sits downstream of the encoder in the host request path and drives the per-channel grant lines. Only one grant is outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 255: grant cycles allowed without ack before abort; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `index`  in  4  encoder output. 0–7 selects a channel; 8–15 (bit3 set) means "no request".
- `index_valid`  in  1  qualifies `index`.
- `ack`  in  8  per-channel acknowledge. Level-sensitive; only the granted bit is examined.
- `grant`  out  8  one-hot grant; all zero when idle.
- `ready`  out  1  high in IDLE; a request is accepted on this cycle.
- `busy`  out  1  high in GRANT or RELEASE.
- `timeout`  out  1  single-cycle pulse on timeout abort.
- `last_index`  out  3  channel of the most recently accepted request.

## Operation
- Three states:
  - IDLE: `ready`=1, `grant`=0.
  - GRANT: `grant[sel]`=1, counter running.
  - RELEASE: `grant`=0, waiting for `ack[sel]` to fall.
- Accept condition: `ready && index_valid && !index[3]`.
  - On accept, latch `sel`=`index[2:0]` and `last_index`, then go to GRANT.
  - `index_valid` with `index[3]`=1 is ignored; the block stays in IDLE with no output change.
- GRANT → RELEASE when `ack[sel]`=1 is sampled.
- GRANT → IDLE on timeout:
  - Timeout occurs when the counter equals `TIMEOUT_CYCLES` and `ack[sel]`=0.
  - `timeout` pulses for one cycle.
  - `ack` and timeout on the same cycle: ack wins and there is no timeout pulse.
- RELEASE → IDLE when `ack[sel]`=0 is sampled.
- Other channels:
  - `ack` bits other than `sel` are ignored in every state.
  - Any `ack` activity in IDLE is ignored.
- `index`/`index_valid` are ignored while `busy`; no queuing.
- Counter:
  - Width is clog2(`TIMEOUT_CYCLES`+1), minimum 1.
  - Cleared on accept, increments each GRANT cycle, and saturates; it never wraps.

## Timing
- Reset values: `grant`=0, `ready`=1, `busy`=0, `timeout`=0, `last_index`=0, state IDLE, counter 0.
- Reset asserted mid-GRANT or mid-RELEASE: all outputs reach reset values at the next edge.
- Accept at edge N: `grant[sel]` and `busy` go high and `ready` goes low, all registered, after edge N.
- `ack[sel]` high sampled at edge M: `grant` is 0 after M.
- Grant-to-drop latency is at least 1 cycle from ack.
- `ack[sel]` low sampled at edge K: `ready`=1 after K, so a new request can be accepted at edge K+1.
- Timeout:
  - With `ack` held low, `grant` stays high for exactly `TIMEOUT_CYCLES`+1 cycles.
  - `timeout` is high during the first IDLE cycle.
  - `ready` is already 1 in that cycle.
- `TIMEOUT_CYCLES`=0: GRANT is held indefinitely until ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `defines.v` holds:
  - the state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - the "no request" index constant (4'h8);
  - the channel count (8).
- Sub-module `index_to_onehot`: combinational 3-bit → 8-bit one-hot decoder. It is used for `grant` generation and for selecting `ack[sel]`.
- The top level contains the FSM, the `sel`/`last_index` registers, and the timeout counter.

## Test plan
- Reset, then `index`=4'h3 with `index_valid` for one cycle → next cycle `grant`=8'h08, `ready`=0, `busy`=1, `last_index`=3.
- From that grant, `ack`=8'h08 for 2 cycles then 0 → `grant`=0 one cycle after ack; `ready`=1 one cycle after ack falls. Asserting `ack`=8'h04 beforehand has no effect.
- `index`=4'h8 and 4'hF with `index_valid` → no grant; `ready` stays 1.
- `TIMEOUT_CYCLES`=4, `index`=4'h7, `ack` held 0:
  - `grant`=8'h80 for exactly 5 cycles;
  - then `timeout` pulses once, `grant`=0, `ready`=1.
- `TIMEOUT_CYCLES`=4, ack arrives on the cycle the counter hits 4 → RELEASE path, `timeout` stays 0.
- Requests `index`=4'h1 while busy, plus `rst` pulsed during GRANT of channel 5 → busy requests ignored; after reset all outputs are at reset values, then a new request `index`=4'h1 gives `grant`=8'h02.

Source files
------------

// File: rtl/grant_sequencer_pkg.sv
// Shared definitions for the grant sequencer: FSM state encodings,
// the "no request" index marker and the channel count.
package grant_sequencer_pkg;

    localparam int NUM_CHANNELS = 8;

    // Any index with bit 3 set means the encoder saw no request
    localparam logic [3:0] NO_REQUEST = 4'h8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } seqState;

    // True when the encoder index names a real channel (0-7)
    function automatic logic isRequest(input logic [3:0] idx);
        return (idx & NO_REQUEST) == 4'h0;
    endfunction

endpackage

// File: rtl/grant_sequencer_index_to_onehot.sv
// Combinational 3-bit channel number to 8-bit one-hot decoder.
module index_to_onehot
    import grant_sequencer_pkg::*;
(
    input  logic [2:0]              code,
    output logic [NUM_CHANNELS-1:0] onehot
);

    // Set exactly the bit named by the channel number
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/grant_sequencer.sv
// Turns the priority encoder's winning index into a one-hot grant,
// holds it until the granted channel acks (or a timeout expires), then
// waits for that ack to drop before accepting the next request.
module grant_sequencer
    import grant_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              index,
    input  logic                    index_valid,
    input  logic [NUM_CHANNELS-1:0] ack,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic                    ready,
    output logic                    busy,
    output logic                    timeout,
    output logic [2:0]              last_index
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seqState                 state;
    logic [2:0]              sel;
    logic [CNT_W-1:0]        count;
    logic [NUM_CHANNELS-1:0] indexOneHot;
    logic [NUM_CHANNELS-1:0] selOneHot;
    logic                    ackSel;
    logic                    acceptReq;
    logic                    timeoutHit;

    // Decoder for the incoming request, used to load the grant register
    index_to_onehot uIndexDecode (
        .code   (index[2:0]),
        .onehot (indexOneHot)
    );

    // Decoder for the latched channel, used to pick out its ack bit
    index_to_onehot uSelDecode (
        .code   (sel),
        .onehot (selOneHot)
    );

    assign ackSel     = |(ack & selOneHot);
    assign acceptReq  = ready && index_valid && isRequest(index);
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (count == CNT_LIMIT);

    // Handshake FSM with registered outputs, channel latch and saturating timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            count      <= '0;
            grant      <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            last_index <= 3'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (acceptReq) begin
                        sel        <= index[2:0];
                        last_index <= index[2:0];
                        count      <= '0;
                        grant      <= indexOneHot;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (ackSel) begin
                        grant <= '0;
                        state <= RELEASE;
                    end else if (timeoutHit) begin
                        grant   <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (count != CNT_MAX) begin
                        count <= count + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (!ackSel) begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_sequencer.sv
// Self-checking bench: two sequencers (timeout 4 and timeout disabled)
// share one stimulus stream and are compared against a cycle model.
module tb_grant_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] index;
    logic       index_valid;
    logic [7:0] ack;

    logic [7:0] grantA, grantB;
    logic       readyA, readyB;
    logic       busyA, busyB;
    logic       timeoutA, timeoutB;
    logic [2:0] lastA, lastB;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state, one entry per DUT
    int mLimit[2] = '{4, 0};
    bit mGranted[2];
    bit mDraining[2];
    bit mTmo[2];
    int mChan[2];
    int mAge[2];
    int mLast[2];

    grant_sequencer #(.TIMEOUT_CYCLES(4)) dutA (
        .clk         (clk),
        .rst         (rst),
        .index       (index),
        .index_valid (index_valid),
        .ack         (ack),
        .grant       (grantA),
        .ready       (readyA),
        .busy        (busyA),
        .timeout     (timeoutA),
        .last_index  (lastA)
    );

    grant_sequencer #(.TIMEOUT_CYCLES(0)) dutB (
        .clk         (clk),
        .rst         (rst),
        .index       (index),
        .index_valid (index_valid),
        .ack         (ack),
        .grant       (grantB),
        .ready       (readyB),
        .busy        (busyB),
        .timeout     (timeoutB),
        .last_index  (lastB)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance model d by one clock edge using the currently applied inputs
    task automatic modelStep(input int d);
        mTmo[d] = 1'b0;
        if (rst) begin
            mGranted[d]  = 1'b0;
            mDraining[d] = 1'b0;
            mChan[d]     = 0;
            mAge[d]      = 0;
            mLast[d]     = 0;
        end else if (mGranted[d]) begin
            if (ack[mChan[d]]) begin
                mGranted[d]  = 1'b0;
                mDraining[d] = 1'b1;
            end else if (mLimit[d] != 0 && mAge[d] >= mLimit[d]) begin
                mGranted[d] = 1'b0;
                mTmo[d]     = 1'b1;
            end else begin
                mAge[d]++;
            end
        end else if (mDraining[d]) begin
            if (!ack[mChan[d]]) mDraining[d] = 1'b0;
        end else if (index_valid && index < 4'd8) begin
            mGranted[d] = 1'b1;
            mChan[d]    = int'(index);
            mLast[d]    = int'(index);
            mAge[d]     = 0;
        end
    endtask

    // One comparison with failure accounting
    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkDut(input int d, input string name, input logic [7:0] g,
                            input logic r, input logic b, input logic t, input logic [2:0] l);
        logic [7:0] expGrant;
        logic       idle;
        expGrant = mGranted[d] ? (8'h01 << mChan[d]) : 8'h00;
        idle     = !mGranted[d] && !mDraining[d];
        checkValue({name, ".grant"},      g,        expGrant);
        checkValue({name, ".ready"},      {7'd0, r}, {7'd0, idle});
        checkValue({name, ".busy"},       {7'd0, b}, {7'd0, !idle});
        checkValue({name, ".timeout"},    {7'd0, t}, {7'd0, mTmo[d]});
        checkValue({name, ".last_index"}, {5'd0, l}, 8'(mLast[d]));
    endtask

    task automatic checkOutput();
        checkDut(0, "dutA", grantA, readyA, busyA, timeoutA, lastA);
        checkDut(1, "dutB", grantB, readyB, busyB, timeoutB, lastB);
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare
    task automatic applyStimulus(input logic r, input logic [3:0] idx,
                                 input logic v, input logic [7:0] a);
        rst         = r;
        index       = idx;
        index_valid = v;
        ack         = a;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkOutput();
    endtask

    initial begin
        int grantCycles;
        int tmoPulses;

        rst         = 1'b1;
        index       = 4'h0;
        index_valid = 1'b0;
        ack         = 8'h00;

        // Reset
        applyStimulus(1'b1, 4'h0, 1'b0, 8'h00);
        applyStimulus(1'b1, 4'h0, 1'b0, 8'h00);

        // Grant channel 3, foreign ack ignored, then ack/drop handshake
        applyStimulus(1'b0, 4'h3, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h04);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h08);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h08);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);

        // "No request" indices are ignored
        applyStimulus(1'b0, 4'h8, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'hF, 1'b1, 8'hFF);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);

        // Timeout on channel 7 with ack held low
        grantCycles = 0;
        tmoPulses   = 0;
        applyStimulus(1'b0, 4'h7, 1'b1, 8'h00);
        if (grantA == 8'h80) grantCycles++;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
            if (grantA == 8'h80) grantCycles++;
            if (timeoutA) tmoPulses++;
        end
        checkValue("tmo.grantCycles", 8'(grantCycles), 8'd5);
        checkValue("tmo.pulses", 8'(tmoPulses), 8'd1);

        // Ack arrives exactly when the counter reaches the limit
        applyStimulus(1'b0, 4'h2, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h04);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);

        // Requests while busy ignored, reset mid-grant, then fresh request
        applyStimulus(1'b0, 4'h5, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'h1, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'h1, 1'b1, 8'h02);
        applyStimulus(1'b1, 4'h1, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'h1, 1'b1, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h02);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          4'($urandom),
                          1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
